ls_usb_tx_sequencer: RTL and testbench
======================================

# ls_usb_tx_sequencer

Packet-level transmit controller for the low-speed USB serializer. It arbitrates between a handshake requester (ACK/NAK/STALL) and a data-packet requester (DATA0/DATA1 with 0–8 byte payload). It frames the granted packet as SYNC, PID, payload and CRC16, feeding one byte per serializer request. It then drives end-of-packet and enforces an inter-packet gap before the next grant.

## Interface
- IPG_CYCLES, default 16: idle clk cycles after eop_done before the next grant.
- MAX_LEN, default 8: maximum payload bytes; larger data_len is clamped.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- hs_req  in  1  level; handshake packet requested; held until hs_done.
- hs_pid  in  4  PID nibble for the handshake; sampled at grant.
- data_req  in  1  level; data packet requested; held until data_done.
- data_pid  in  4  DATA0 = 0x3 / DATA1 = 0xB; sampled at grant.
- data_len  in  4  payload length; sampled at grant.
- data_byte  in  8  payload byte; valid in the same cycle as data_rd.
- data_rd  out  1  one-cycle pulse; consumes data_byte.
- byte_req  in  1  one-cycle pulse from serializer; the previous byte is taken and the next is wanted.
- eop_done  in  1  one-cycle pulse from serializer; SE0 and J have been completed on the line.
- send_reg  out  8  byte to serializer, LSB transmitted first.
- sdata_ready  out  1  one-cycle load strobe for send_reg.
- SOP  out  1  one-cycle start-of-packet pulse; resets the serializer bit timer.
- sEOP  out  1  level; high from the cycle after the last CRC byte is taken until eop_done.
- hs_done, data_done  out  1  one-cycle completion pulses.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, START, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, GAP.
- IDLE:
  - If hs_req is set, grant the handshake. Else, if data_req is set, grant the data packet.
  - Handshake has fixed priority. A non-granted request stays pending and gets no pulse.
  - On grant, latch pid, len = min(data_len, MAX_LEN) and type.
  - Load crc = 0xFFFF and go to START.
- START: pulse SOP for one cycle, then load send_reg = 0x80 and pulse sdata_ready. Go to SYNC.
- On each byte_req, the next state's byte is loaded and sdata_ready is pulsed.
  - SYNC→PID: send_reg = {~pid, pid}. Examples: ACK 0xD2, NAK 0x5A, STALL 0x1E, DATA0 0xC3, DATA1 0x4B.
  - Handshake packets go PID→EOP.
  - Data packets with len > 0 go PID→DATA.
  - Data packets with len = 0 go PID→CRC_LO.
- DATA:
  - Each byte_req pulses data_rd, forwards data_byte to send_reg, folds it into crc and decrements the remaining count.
  - The CRC_LO byte is loaded on the byte_req after the last payload byte.
- CRC16 (USB):
  - Polynomial 0x8005, reflected; LSB of each byte first; init 0xFFFF.
  - Transmit ~crc: low byte in CRC_LO, high byte in CRC_HI.
  - The update completes within one cycle (8 bit steps unrolled), before the next byte_req.
- EOP: entered on the byte_req that takes the last byte (PID or CRC_HI). sEOP is high; no sdata_ready is issued. On eop_done, drop sEOP, pulse hs_done or data_done, and go to GAP.
- GAP: count IPG_CYCLES clk cycles, then go to IDLE. Requests are ignored during GAP.
- A byte_req in IDLE, GAP or EOP is ignored. An eop_done outside EOP is ignored.

## Timing
- Reset values:
  - Outputs: send_reg 0x00, and all strobes, sEOP and busy 0.
  - Internal: state IDLE, crc 0xFFFF.
- Reset mid-packet aborts immediately. No done pulse is issued, and the requester must re-request.
- Grant latency: request seen in IDLE → SOP on the next cycle → sdata_ready (SYNC) the cycle after.
- byte_req → sdata_ready with the new send_reg: exactly 1 cycle.
- data_rd coincides with the cycle in which byte_req is sampled.
- Back-to-back: the earliest next SOP is IPG_CYCLES+1 cycles after eop_done.
- hs_req rising while a data packet is in flight does not preempt it. The handshake wins the next IDLE arbitration.

## Test plan
- hs_req with hs_pid 0x2 → SOP, send_reg sequence 0x80, 0xD2 → sEOP until eop_done → hs_done pulse.
- data_req with DATA0 and len 0 → 0x80, 0xC3, 0x00, 0x00 → data_done; data_rd never pulses.
- DATA1 with len 4 (bytes 0x00–0x03) → 0x80, 0x4B, the 4 bytes, then 2 CRC bytes matching a bit-serial reference model; exactly 4 data_rd pulses.
- hs_req and data_req asserted in the same cycle → handshake first; data packet SOP exactly IPG_CYCLES+1 cycles after its eop_done.
- data_len 12 → exactly 8 payload bytes, 8 data_rd pulses, CRC computed over those 8 bytes.
- rst asserted during DATA → all outputs 0 immediately, no done pulse; after release, the held data_req restarts from SOP.

Source files
------------

// File: rtl/ls_usb_tx_sequencer_if.sv
// Request, payload and serializer handshake bundle
// for the low-speed USB transmit sequencer.
interface ls_usb_tx_sequencer_if;
   logic       hs_req;
   logic [3:0] hs_pid;
   logic       data_req;
   logic [3:0] data_pid;
   logic [3:0] data_len;
   logic [7:0] data_byte;
   logic       data_rd;
   logic       byte_req;
   logic       eop_done;
   logic [7:0] send_reg;
   logic       sdata_ready;
   logic       SOP;
   logic       sEOP;
   logic       hs_done;
   logic       data_done;
   logic       busy;

   modport master (
      output hs_req, hs_pid,
      output data_req, data_pid, data_len,
      output data_byte, byte_req, eop_done,
      input  data_rd, send_reg, sdata_ready,
      input  SOP, sEOP, hs_done, data_done,
      input  busy
   );

   modport slave (
      input  hs_req, hs_pid,
      input  data_req, data_pid, data_len,
      input  data_byte, byte_req, eop_done,
      output data_rd, send_reg, sdata_ready,
      output SOP, sEOP, hs_done, data_done,
      output busy
   );
endinterface

// File: rtl/ls_usb_tx_sequencer.sv
// Low-speed USB packet transmit sequencer: arbitrates
// handshake/data requests and frames SYNC/PID/data/CRC16.
module ls_usb_tx_sequencer #(
   parameter int IPG_CYCLES = 16,
   parameter int MAX_LEN    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   ls_usb_tx_sequencer_if.slave  bus
);

   typedef enum logic [3:0] {
      IDLE, START, SYNC, PID, DATA,
      CRC_LO, CRC_HI, EOP, GAP
   } state_t;

   localparam int GW =
      (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

   state_t        state;
   logic [3:0]    pid;
   logic [3:0]    remain;
   logic          is_data;
   logic [15:0]   crc;
   logic [GW-1:0] gap_cnt;
   logic [3:0]    len_clamp;
   logic          rd_ok;

   // Reflected CRC16 (poly 0x8005), LSB of the byte first.
   function automatic logic [15:0] crc_byte(
      input logic [15:0] c,
      input logic [7:0]  d
   );
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i])
            r = (r >> 1) ^ 16'hA001;
         else
            r = r >> 1;
      end
      return r;
   endfunction

   assign len_clamp =
      (bus.data_len > 4'(MAX_LEN)) ? 4'(MAX_LEN)
                                   : bus.data_len;

   // The next byte is payload while bytes remain after PID.
   assign rd_ok = (remain != 4'd0) &&
                  ((state == DATA) ||
                   (state == PID && is_data));

   assign bus.data_rd = bus.byte_req && rd_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         pid             <= 4'h0;
         remain          <= 4'd0;
         is_data         <= 1'b0;
         crc             <= 16'hFFFF;
         gap_cnt         <= '0;
         bus.send_reg    <= 8'h00;
         bus.sdata_ready <= 1'b0;
         bus.SOP         <= 1'b0;
         bus.sEOP        <= 1'b0;
         bus.hs_done     <= 1'b0;
         bus.data_done   <= 1'b0;
         bus.busy        <= 1'b0;
      end else begin
         bus.sdata_ready <= 1'b0;
         bus.SOP         <= 1'b0;
         bus.hs_done     <= 1'b0;
         bus.data_done   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.hs_req) begin
                  pid      <= bus.hs_pid;
                  is_data  <= 1'b0;
                  remain   <= 4'd0;
                  crc      <= 16'hFFFF;
                  bus.SOP  <= 1'b1;
                  bus.busy <= 1'b1;
                  state    <= START;
               end else if (bus.data_req) begin
                  pid      <= bus.data_pid;
                  is_data  <= 1'b1;
                  remain   <= len_clamp;
                  crc      <= 16'hFFFF;
                  bus.SOP  <= 1'b1;
                  bus.busy <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               bus.send_reg    <= 8'h80;
               bus.sdata_ready <= 1'b1;
               state           <= SYNC;
            end
            SYNC: begin
               if (bus.byte_req) begin
                  bus.send_reg    <= {~pid, pid};
                  bus.sdata_ready <= 1'b1;
                  state           <= PID;
               end
            end
            PID, DATA: begin
               if (bus.byte_req) begin
                  if (!is_data) begin
                     bus.sEOP <= 1'b1;
                     state    <= EOP;
                  end else if (rd_ok) begin
                     bus.send_reg    <= bus.data_byte;
                     bus.sdata_ready <= 1'b1;
                     crc    <= crc_byte(crc, bus.data_byte);
                     remain <= remain - 4'd1;
                     state  <= DATA;
                  end else begin
                     bus.send_reg    <= ~crc[7:0];
                     bus.sdata_ready <= 1'b1;
                     state           <= CRC_LO;
                  end
               end
            end
            CRC_LO: begin
               if (bus.byte_req) begin
                  bus.send_reg    <= ~crc[15:8];
                  bus.sdata_ready <= 1'b1;
                  state           <= CRC_HI;
               end
            end
            CRC_HI: begin
               if (bus.byte_req) begin
                  bus.sEOP <= 1'b1;
                  state    <= EOP;
               end
            end
            EOP: begin
               if (bus.eop_done) begin
                  bus.sEOP      <= 1'b0;
                  bus.hs_done   <= !is_data;
                  bus.data_done <= is_data;
                  gap_cnt       <= '0;
                  if (IPG_CYCLES == 0) begin
                     bus.busy <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GW'(IPG_CYCLES - 1)) begin
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ls_usb_tx_sequencer.sv
// Directed self-checking bench for ls_usb_tx_sequencer
// with a bit-serial CRC16 reference model.
module tb_ls_usb_tx_sequencer;

   localparam int IPG = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ls_usb_tx_sequencer_if bus();

   ls_usb_tx_sequencer #(
      .IPG_CYCLES (IPG),
      .MAX_LEN    (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int   checks = 0;
   int   fails  = 0;
   int   rd_cnt = 0;
   int   hs_cnt = 0;
   int   dd_cnt = 0;
   logic rd_now;

   always @(negedge clk) begin
      if (bus.data_rd)   rd_cnt++;
      if (bus.hs_done)   hs_cnt++;
      if (bus.data_done) dd_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_byte(input logic [7:0] d);
      tick();
      bus.byte_req  = 1'b1;
      bus.data_byte = d;
      #1 rd_now = bus.data_rd;
      @(posedge clk);
      #1 bus.byte_req = 1'b0;
   endtask

   task automatic eop_pulse();
      tick();
      bus.eop_done = 1'b1;
      @(posedge clk);
      #1 bus.eop_done = 1'b0;
   endtask

   // Non-reflected serial form; transmitted value is
   // bit-reversed ~crc so low byte goes out first.
   function automatic logic [15:0] usb_crc(input int n,
                                           input logic [7:0] base);
      logic [15:0] c;
      logic [15:0] r;
      logic [7:0]  v;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         v = base + 8'(i);
         for (int b = 0; b < 8; b++) begin
            fb = v[b] ^ c[15];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h8005;
         end
      end
      for (int k = 0; k < 16; k++) r[k] = ~c[15-k];
      return r;
   endfunction

   // Runs a data packet from the SOP cycle to its done pulse.
   task automatic data_body(input string tag,
                            input logic [7:0] pid_b,
                            input int n,
                            input logic [7:0] base);
      logic [15:0] rc;
      int          rd0;
      logic [7:0]  v;
      rc  = usb_crc(n, base);
      rd0 = rd_cnt;
      tick();
      chk({tag, "_sync"},
          16'({bus.sdata_ready, bus.send_reg}), 16'h0180);
      do_byte(8'h00);
      chk({tag, "_pid"},
          16'({bus.sdata_ready, bus.send_reg}),
          16'({1'b1, pid_b}));
      for (int i = 0; i < n; i++) begin
         v = base + 8'(i);
         do_byte(v);
         chk({tag, "_data"},
             16'({rd_now, bus.sdata_ready, bus.send_reg}),
             16'({2'b11, v}));
      end
      do_byte(8'hEE);
      chk({tag, "_crc_lo"},
          16'({rd_now, bus.sdata_ready, bus.send_reg}),
          16'({2'b01, rc[7:0]}));
      do_byte(8'hEE);
      chk({tag, "_crc_hi"},
          16'({bus.sdata_ready, bus.send_reg}),
          16'({1'b1, rc[15:8]}));
      do_byte(8'hEE);
      chk({tag, "_eop"},
          16'({bus.sdata_ready, bus.sEOP}), 16'h0001);
      chk({tag, "_rd_count"}, 16'(rd_cnt - rd0), 16'(n));
      eop_pulse();
      chk({tag, "_done"},
          16'({bus.data_done, bus.hs_done, bus.sEOP}),
          16'h0004);
   endtask

   task automatic wait_idle();
      repeat (IPG + 2) tick();
   endtask

   int n;

   initial begin
      bus.hs_req    = 1'b0;
      bus.hs_pid    = 4'h0;
      bus.data_req  = 1'b0;
      bus.data_pid  = 4'h0;
      bus.data_len  = 4'h0;
      bus.data_byte = 8'h00;
      bus.byte_req  = 1'b0;
      bus.eop_done  = 1'b0;

      // Reset values
      repeat (2) tick();
      chk("reset_outs",
          16'({bus.send_reg, bus.sdata_ready, bus.SOP,
               bus.sEOP, bus.busy, bus.data_rd,
               bus.hs_done, bus.data_done}), 16'h0000);
      rst = 1'b0;
      tick();

      // Stray byte_req / eop_done in IDLE
      do_byte(8'h5C);
      eop_pulse();
      chk("idle_ignore",
          16'({bus.sdata_ready, bus.busy, bus.sEOP,
               bus.hs_done, bus.data_done}), 16'h0000);

      // Handshake ACK
      bus.hs_req = 1'b1;
      bus.hs_pid = 4'h2;
      tick();
      chk("ack_sop",
          16'({bus.SOP, bus.busy, bus.sdata_ready}), 16'h0006);
      tick();
      chk("ack_sync",
          16'({bus.SOP, bus.sdata_ready, bus.send_reg}),
          16'h0180);
      do_byte(8'h00);
      chk("ack_pid",
          16'({bus.sdata_ready, bus.send_reg}), 16'h01D2);
      do_byte(8'h00);
      chk("ack_eop",
          16'({bus.sdata_ready, bus.sEOP}), 16'h0001);
      tick();
      chk("ack_eop_hold", 16'(bus.sEOP), 16'h0001);
      eop_pulse();
      chk("ack_done",
          16'({bus.hs_done, bus.data_done, bus.sEOP, bus.busy}),
          16'h0009);
      bus.hs_req = 1'b0;
      tick();
      chk("ack_done_pulse", 16'(bus.hs_done), 16'h0000);
      wait_idle();
      chk("ack_idle", 16'(bus.busy), 16'h0000);

      // DATA0, zero length
      bus.data_req = 1'b1;
      bus.data_pid = 4'h3;
      bus.data_len = 4'd0;
      tick();
      chk("d0_sop", 16'(bus.SOP), 16'h0001);
      data_body("d0", 8'hC3, 0, 8'h00);
      bus.data_req = 1'b0;
      wait_idle();

      // DATA1, four bytes 00..03
      bus.data_req = 1'b1;
      bus.data_pid = 4'hB;
      bus.data_len = 4'd4;
      tick();
      chk("d1_sop", 16'(bus.SOP), 16'h0001);
      data_body("d1", 8'h4B, 4, 8'h00);
      bus.data_req = 1'b0;
      wait_idle();

      // Simultaneous requests: NAK first, then DATA0
      bus.hs_req   = 1'b1;
      bus.hs_pid   = 4'hA;
      bus.data_req = 1'b1;
      bus.data_pid = 4'h3;
      bus.data_len = 4'd2;
      tick();
      chk("pri_sop", 16'(bus.SOP), 16'h0001);
      tick();
      chk("pri_sync",
          16'({bus.sdata_ready, bus.send_reg}), 16'h0180);
      do_byte(8'h00);
      chk("pri_nak",
          16'({bus.sdata_ready, bus.send_reg}), 16'h015A);
      do_byte(8'h00);
      chk("pri_eop", 16'(bus.sEOP), 16'h0001);
      eop_pulse();
      chk("pri_hs_done",
          16'({bus.hs_done, bus.data_done}), 16'h0002);
      bus.hs_req = 1'b0;
      n = 0;
      while (!bus.SOP && n < 100) begin
         tick();
         n++;
      end
      chk("pri_gap", 16'(n), 16'(IPG + 1));
      data_body("pri_d", 8'hC3, 2, 8'hA5);
      bus.data_req = 1'b0;
      wait_idle();

      // Length clamp: 12 requested, 8 sent
      bus.data_req = 1'b1;
      bus.data_pid = 4'h3;
      bus.data_len = 4'd12;
      tick();
      chk("clamp_sop", 16'(bus.SOP), 16'h0001);
      data_body("clamp", 8'hC3, 8, 8'h10);
      bus.data_req = 1'b0;
      wait_idle();

      // Reset in DATA, then restart from the held request
      bus.data_req = 1'b1;
      bus.data_pid = 4'hB;
      bus.data_len = 4'd4;
      tick();
      chk("rst_sop", 16'(bus.SOP), 16'h0001);
      tick();
      do_byte(8'h00);
      do_byte(8'h55);
      chk("rst_in_data",
          16'({bus.sdata_ready, bus.send_reg}), 16'h0155);
      n = dd_cnt;
      rst = 1'b1;
      #1;
      chk("rst_outs",
          16'({bus.send_reg, bus.sdata_ready, bus.SOP,
               bus.sEOP, bus.busy, bus.data_rd,
               bus.hs_done, bus.data_done}), 16'h0000);
      repeat (2) tick();
      chk("rst_no_done", 16'(dd_cnt - n), 16'h0000);
      rst = 1'b0;
      tick();
      chk("rst_restart",
          16'({bus.SOP, bus.busy}), 16'h0003);
      data_body("rst_d", 8'h4B, 4, 8'h20);
      bus.data_req = 1'b0;
      wait_idle();

      chk("hs_total", 16'(hs_cnt), 16'd2);
      chk("data_total", 16'(dd_cnt), 16'd5);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
